// File: rtl/tc_fetch_unit8.sv
// Instruction fetch stage: owns the PC, drives the program memory address and
// hands captured 32-bit words to decode over a valid/ready handshake.
module tc_fetch_unit8 #(
    parameter logic [7:0]  PC_RESET   = 8'h00,
    parameter int unsigned STEP       = 4,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  address,
    input  logic [7:0]  mem_b0,
    input  logic [7:0]  mem_b1,
    input  logic [7:0]  mem_b2,
    input  logic [7:0]  mem_b3,
    output logic [31:0] instr,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump_en,
    input  logic [7:0]  jump_target,
    input  logic        halt,
    input  logic        start,
    output logic        running,
    output logic [15:0] fetch_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [7:0] STEP8 = 8'(STEP);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  pc;
    logic        accept;
    logic        load;

    assign address = pc;
    assign running = (state == RUN);
    assign accept  = instr_valid & instr_ready;
    assign load    = (state == RUN) & (~instr_valid | accept) & ~jump_en & ~halt;

    // A jump leaves the run/halt state untouched, even if halt or start is also set.
    always_comb begin
        state_nxt = state;
        if (!jump_en) begin
            case (state)
                RUN:     if (halt) state_nxt = HALTED;
                HALTED:  if (start && !halt) state_nxt = RUN;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= AUTO_START ? RUN : HALTED;
            pc          <= PC_RESET;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                fetch_count <= fetch_count + 16'd1;
            if (jump_en) begin
                pc          <= jump_target;
                instr_valid <= 1'b0;
            end else if (load) begin
                instr       <= {mem_b3, mem_b2, mem_b1, mem_b0};
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + STEP8;
            end else if (accept) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tc_fetch_unit8.sv
// Bench for tc_fetch_unit8: directed vector table followed by randomized
// traffic checked against a cycle-level reference model.
module tb_tc_fetch_unit8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  address;
    logic [7:0]  mem_b0, mem_b1, mem_b2, mem_b3;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        jump_en = 1'b0;
    logic [7:0]  jump_target = '0;
    logic        halt = 1'b0;
    logic        start = 1'b0;
    logic        running;
    logic [15:0] fetch_count;

    logic [7:0]  mem [256];
    logic [7:0]  a1, a2, a3;

    int tests  = 0;
    int failed = 0;

    tc_fetch_unit8 #(.PC_RESET(8'h00), .STEP(4), .AUTO_START(1'b1)) dut (
        .clk(clk), .rst(rst), .address(address),
        .mem_b0(mem_b0), .mem_b1(mem_b1), .mem_b2(mem_b2), .mem_b3(mem_b3),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .jump_en(jump_en), .jump_target(jump_target),
        .halt(halt), .start(start), .running(running), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        a1 = address + 8'd1;
        a2 = address + 8'd2;
        a3 = address + 8'd3;
        mem_b0 = mem[address];
        mem_b1 = mem[a1];
        mem_b2 = mem[a2];
        mem_b3 = mem[a3];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, rdy, jmp;
        logic [7:0]  tgt;
        logic        hlt, stt;
        logic [7:0]  e_pc;
        logic        e_valid;
        logic [7:0]  e_ipc;
        logic [31:0] e_instr;
        logic [15:0] e_cnt;
        logic        e_run;
    } vec_t;

    vec_t vecs[21];

    // Reference model state
    logic [7:0]  m_pc, m_ipc;
    logic [31:0] m_instr;
    logic        m_valid, m_run;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_pc = 8'h00; m_ipc = 8'h00; m_instr = '0;
        m_valid = 1'b0; m_run = 1'b1; m_cnt = '0;
    endtask

    task automatic model_step(input logic r, input logic rdy, input logic jmp,
                              input logic [7:0] tgt, input logic hlt, input logic stt);
        logic acc, ld;
        logic [31:0] word;
        if (r) begin
            model_reset();
            return;
        end
        word = {mem[8'(m_pc + 8'd3)], mem[8'(m_pc + 8'd2)], mem[8'(m_pc + 8'd1)], mem[m_pc]};
        acc = m_valid && rdy;
        ld  = m_run && (!m_valid || acc) && !jmp && !hlt;
        if (acc) m_cnt = m_cnt + 16'd1;
        if (jmp) begin
            m_pc = tgt;
            m_valid = 1'b0;
        end else begin
            if (ld) begin
                m_instr = word; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 8'd4;
            end else if (acc) begin
                m_valid = 1'b0;
            end
            if (m_run && hlt) m_run = 1'b0;
            else if (!m_run && stt && !hlt) m_run = 1'b1;
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic jmp,
                         input logic [7:0] tgt, input logic hlt, input logic stt);
        rst = r; instr_ready = rdy; jump_en = jmp; jump_target = tgt; halt = hlt; start = stt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        vecs[0]  = '{0,1,0,8'h00,0,0, 8'h04,1,8'h00,32'h03020100,16'd0,1};
        vecs[1]  = '{0,1,0,8'h00,0,0, 8'h08,1,8'h04,32'h07060504,16'd1,1};
        vecs[2]  = '{0,1,0,8'h00,0,0, 8'h0C,1,8'h08,32'h0B0A0908,16'd2,1};
        vecs[3]  = '{0,0,0,8'h00,0,0, 8'h0C,1,8'h08,32'h0B0A0908,16'd2,1};
        vecs[4]  = '{0,0,0,8'h00,0,0, 8'h0C,1,8'h08,32'h0B0A0908,16'd2,1};
        vecs[5]  = '{0,0,0,8'h00,0,0, 8'h0C,1,8'h08,32'h0B0A0908,16'd2,1};
        vecs[6]  = '{0,1,0,8'h00,0,0, 8'h10,1,8'h0C,32'h0F0E0D0C,16'd3,1};
        vecs[7]  = '{0,1,0,8'h00,0,0, 8'h14,1,8'h10,32'h13121110,16'd4,1};
        vecs[8]  = '{0,1,1,8'h40,0,0, 8'h40,0,8'h10,32'h13121110,16'd5,1};
        vecs[9]  = '{0,1,0,8'h00,0,0, 8'h44,1,8'h40,32'h43424140,16'd5,1};
        vecs[10] = '{0,0,0,8'h00,1,0, 8'h44,1,8'h40,32'h43424140,16'd5,0};
        vecs[11] = '{0,1,1,8'h10,0,0, 8'h10,0,8'h40,32'h43424140,16'd6,0};
        vecs[12] = '{0,1,0,8'h00,0,0, 8'h10,0,8'h40,32'h43424140,16'd6,0};
        vecs[13] = '{0,1,0,8'h00,0,1, 8'h10,0,8'h40,32'h43424140,16'd6,1};
        vecs[14] = '{0,1,0,8'h00,0,0, 8'h14,1,8'h10,32'h13121110,16'd6,1};
        vecs[15] = '{0,1,0,8'h00,1,1, 8'h14,0,8'h10,32'h13121110,16'd7,0};
        vecs[16] = '{0,1,0,8'h00,0,1, 8'h14,0,8'h10,32'h13121110,16'd7,1};
        vecs[17] = '{0,1,1,8'hFC,0,0, 8'hFC,0,8'h10,32'h13121110,16'd7,1};
        vecs[18] = '{0,1,0,8'h00,0,0, 8'h00,1,8'hFC,32'hFFFEFDFC,16'd7,1};
        vecs[19] = '{0,1,0,8'h00,0,0, 8'h04,1,8'h00,32'h03020100,16'd8,1};
        vecs[20] = '{1,1,0,8'h00,0,0, 8'h00,0,8'h00,32'h00000000,16'd0,1};

        drive(1, 0, 0, 8'h00, 0, 0);
        drive(1, 0, 0, 8'h00, 0, 0);
        chk("reset address", 32'(address), 32'h00);
        chk("reset valid", 32'(instr_valid), 32'h0);
        chk("reset count", 32'(fetch_count), 32'h0);
        chk("reset running", 32'(running), 32'h1);
        chk("reset instr", instr, 32'h0);
        chk("reset instr_pc", 32'(instr_pc), 32'h0);

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].jmp, vecs[i].tgt, vecs[i].hlt, vecs[i].stt);
            chk($sformatf("vec%0d address", i), 32'(address), 32'(vecs[i].e_pc));
            chk($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d instr_pc", i), 32'(instr_pc), 32'(vecs[i].e_ipc));
            chk($sformatf("vec%0d instr", i), instr, vecs[i].e_instr);
            chk($sformatf("vec%0d count", i), 32'(fetch_count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d running", i), 32'(running), 32'(vecs[i].e_run));
        end

        // Randomized phase with scrambled memory contents
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        drive(1, 0, 0, 8'h00, 0, 0);
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic r, rdy, jmp, hlt, stt;
            logic [7:0] tgt;
            r   = ($urandom_range(0, 249) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            jmp = ($urandom_range(0, 15) == 0);
            tgt = 8'($urandom);
            hlt = ($urandom_range(0, 11) == 0);
            stt = ($urandom_range(0, 5) == 0);
            model_step(r, rdy, jmp, tgt, hlt, stt);
            drive(r, rdy, jmp, tgt, hlt, stt);
            chk("rand address", 32'(address), 32'(m_pc));
            chk("rand valid", 32'(instr_valid), 32'(m_valid));
            chk("rand instr_pc", 32'(instr_pc), 32'(m_ipc));
            chk("rand instr", instr, m_instr);
            chk("rand count", 32'(fetch_count), 32'(m_cnt));
            chk("rand running", 32'(running), 32'(m_run));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
